// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared Common Data Bus: one combinational grant per cycle,
// winner's fields broadcast from a registered CDB output stage.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 3,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_result,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
  input  logic [NUM_REQ*5-1:0]            req_dest_reg,
  output logic [NUM_REQ-1:0]              req_ack,
  input  logic                            cdb_ready,
  output logic                            cdb_valid,
  output logic [DATA_WIDTH-1:0]           cdb_result,
  output logic [TAG_WIDTH-1:0]            cdb_tag,
  output logic [4:0]                      cdb_dest_reg,
  output logic [IDX_WIDTH-1:0]            cdb_src
);

  logic                  cdb_valid_q, cdb_valid_d;
  logic [DATA_WIDTH-1:0] cdb_result_q, cdb_result_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [4:0]            cdb_dest_reg_q, cdb_dest_reg_d;
  logic [IDX_WIDTH-1:0]  cdb_src_q, cdb_src_d;
  logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic                  found;
  logic [IDX_WIDTH-1:0]  win;
  logic [IDX_WIDTH-1:0]  scan_idx;
  int                    scan;

  // Scan from rr_ptr upward; explicit wrap keeps non-power-of-2 NUM_REQ correct.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan     = 0;
    scan_idx = '0;
    if (!rst && cdb_ready) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        scan = int'(rr_ptr_q) + k;
        if (scan >= int'(NUM_REQ)) scan = scan - int'(NUM_REQ);
        scan_idx = IDX_WIDTH'(scan);
        if (!found && req_valid[scan_idx]) begin
          found = 1'b1;
          win   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    req_ack        = '0;
    cdb_valid_d    = found;
    cdb_result_d   = cdb_result_q;
    cdb_tag_d      = cdb_tag_q;
    cdb_dest_reg_d = cdb_dest_reg_q;
    cdb_src_d      = cdb_src_q;
    rr_ptr_d       = rr_ptr_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (found && (win == IDX_WIDTH'(i))) begin
        req_ack[i]     = 1'b1;
        cdb_result_d   = req_result[i*DATA_WIDTH +: DATA_WIDTH];
        cdb_tag_d      = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        cdb_dest_reg_d = req_dest_reg[i*5 +: 5];
      end
    end
    if (found) begin
      cdb_src_d = win;
      rr_ptr_d  = (win == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q    <= 1'b0;
      cdb_result_q   <= '0;
      cdb_tag_q      <= '0;
      cdb_dest_reg_q <= '0;
      cdb_src_q      <= '0;
      rr_ptr_q       <= '0;
    end else begin
      cdb_valid_q    <= cdb_valid_d;
      cdb_result_q   <= cdb_result_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_dest_reg_q <= cdb_dest_reg_d;
      cdb_src_q      <= cdb_src_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_result   = cdb_result_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_dest_reg = cdb_dest_reg_q;
  assign cdb_src      = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a
// round-robin reference model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_result;
  logic [N*TW-1:0]   req_tag;
  logic [N*5-1:0]    req_dest_reg;
  logic [N-1:0]      req_ack;
  logic              cdb_ready;
  logic              cdb_valid;
  logic [DW-1:0]     cdb_result;
  logic [TW-1:0]     cdb_tag;
  logic [4:0]        cdb_dest_reg;
  logic [IW-1:0]     cdb_src;

  cdb_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_result(req_result),
    .req_tag(req_tag), .req_dest_reg(req_dest_reg), .req_ack(req_ack),
    .cdb_ready(cdb_ready), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
    .cdb_tag(cdb_tag), .cdb_dest_reg(cdb_dest_reg), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int            m_ptr = 0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_result = '0;
  logic [TW-1:0] exp_tag = '0;
  logic [4:0]    exp_dest = '0;
  logic [IW-1:0] exp_src = '0;

  function automatic int winner(input logic [N-1:0] v, input int ptr, input logic rdy);
    logic [N-1:0] s;
    if (!rdy) return -1;
    for (int k = 0; k < N; k++) begin
      s = v >> ((ptr + k) % N);
      if (s[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] r, input logic [TW-1:0] t,
                         input logic [4:0] d);
    req_result[i*DW +: DW] = r;
    req_tag[i*TW +: TW]    = t;
    req_dest_reg[i*5 +: 5] = d;
  endtask

  task automatic drop(input int i);
    req_valid = req_valid & ~(N'(1) << i);
  endtask

  // Advance one clock and step the model with the inputs seen at that edge.
  task automatic tick();
    int w;
    w = rst ? -1 : winner(req_valid, m_ptr, cdb_ready);
    @(posedge clk);
    if (rst) begin
      exp_valid = 1'b0; exp_result = '0; exp_tag = '0; exp_dest = '0; exp_src = '0;
      m_ptr = 0;
    end else if (w >= 0) begin
      exp_valid  = 1'b1;
      exp_result = req_result[w*DW +: DW];
      exp_tag    = req_tag[w*TW +: TW];
      exp_dest   = req_dest_reg[w*5 +: 5];
      exp_src    = IW'(w);
      m_ptr      = (w + 1) % N;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cdb_ready = 1'b1; req_valid = 4'b1111;
    req_result = '1; req_tag = '1; req_dest_reg = '1;
    #1;
    checks++;
    if (req_ack !== 4'b0000) begin
      failures++; $display("FAIL reset_ack: got %b want 0000", req_ack);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_result, cdb_tag, cdb_dest_reg, cdb_src} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b r=%h t=%0d d=%0d s=%0d want all zero",
               cdb_valid, cdb_result, cdb_tag, cdb_dest_reg, cdb_src);
    end
    rst = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    set_req(1, 32'h3F80_0000, 3'd5, 5'd7);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ack !== 4'b0010) begin
      failures++; $display("FAIL single_ack: got %b want 0010", req_ack);
    end
    tick();
    req_valid = '0;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_result !== 32'h3F80_0000 || cdb_tag !== 3'd5 ||
        cdb_dest_reg !== 5'd7 || cdb_src !== 2'd1) begin
      failures++;
      $display("FAIL single_bcast: got v=%b r=%h t=%0d d=%0d s=%0d want 1 3f800000 5 7 1",
               cdb_valid, cdb_result, cdb_tag, cdb_dest_reg, cdb_src);
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++; $display("FAIL single_drop: cdb_valid got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'hA000_0000 + DW'(i), TW'(i + 2), 5'(i + 10));
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) begin
      #1;
      checks++;
      if (req_ack !== onehot(k)) begin
        failures++; $display("FAIL all4_ack%0d: got %b want %b", k, req_ack, onehot(k));
      end
      tick();
      drop(k);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== IW'(k) || cdb_result !== 32'hA000_0000 + DW'(k)
          || cdb_tag !== TW'(k + 2) || cdb_dest_reg !== 5'(k + 10)) begin
        failures++;
        $display("FAIL all4_bcast%0d: got v=%b s=%0d r=%h t=%0d d=%0d", k, cdb_valid,
                 cdb_src, cdb_result, cdb_tag, cdb_dest_reg);
      end
    end
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || m_ptr != 0) begin
      failures++; $display("FAIL all4_end: cdb_valid got %b want 0", cdb_valid);
    end
  endtask

  task automatic test_alternate();
    int want;
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      want = (k % 2 == 0) ? 0 : 2;
      #1;
      checks++;
      if (req_ack !== onehot(want)) begin
        failures++; $display("FAIL alt_ack%0d: got %b want %b", k, req_ack, onehot(want));
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b1 || cdb_src !== IW'(want)) begin
        failures++; $display("FAIL alt_src%0d: got v=%b s=%0d want 1 %0d", k, cdb_valid,
                             cdb_src, want);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_wrap();
    // Last grant was FU2, so the pointer now sits at 3.
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ack !== 4'b1000) begin
      failures++; $display("FAIL wrap_ack3: got %b want 1000", req_ack);
    end
    tick();
    drop(3);
    checks++;
    if (cdb_src !== 2'd3 || cdb_valid !== 1'b1) begin
      failures++; $display("FAIL wrap_src3: got v=%b s=%0d want 1 3", cdb_valid, cdb_src);
    end
    #1;
    checks++;
    if (req_ack !== 4'b0010) begin
      failures++; $display("FAIL wrap_ack1: got %b want 0010", req_ack);
    end
    tick();
    drop(1);
    checks++;
    if (cdb_src !== 2'd1 || cdb_valid !== 1'b1) begin
      failures++; $display("FAIL wrap_src1: got v=%b s=%0d want 1 1", cdb_valid, cdb_src);
    end
    tick();
  endtask

  task automatic test_stall();
    set_req(2, 32'hDEAD_BEEF, 3'd6, 5'd19);
    req_valid = 4'b0100; cdb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ack !== 4'b0000) begin
        failures++; $display("FAIL stall_ack%0d: got %b want 0000", k, req_ack);
      end
      tick();
      checks++;
      if (cdb_valid !== 1'b0) begin
        failures++; $display("FAIL stall_valid%0d: got %b want 0", k, cdb_valid);
      end
    end
    cdb_ready = 1'b1;
    #1;
    checks++;
    if (req_ack !== 4'b0100) begin
      failures++; $display("FAIL stall_resume_ack: got %b want 0100", req_ack);
    end
    tick();
    req_valid = '0;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd2 || cdb_result !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL stall_resume_bcast: got v=%b s=%0d r=%h", cdb_valid,
                           cdb_src, cdb_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1001;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (req_ack !== 4'b0000) begin
      failures++; $display("FAIL midrst_ack: got %b want 0000", req_ack);
    end
    tick();
    checks++;
    if ({cdb_valid, cdb_result, cdb_tag, cdb_dest_reg, cdb_src} !== '0) begin
      failures++; $display("FAIL midrst_outputs: got v=%b r=%h t=%0d d=%0d s=%0d",
                           cdb_valid, cdb_result, cdb_tag, cdb_dest_reg, cdb_src);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ack !== 4'b0001) begin
      failures++; $display("FAIL midrst_tie: got %b want 0001", req_ack);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int w;
    int waits [N];
    logic [N-1:0] ea;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 400; c++) begin
      cdb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        logic [N-1:0] s;
        s = req_valid >> i;
        if (!s[0] && $urandom_range(0, 2) != 0) begin
          set_req(i, $urandom, TW'($urandom), 5'($urandom));
          req_valid = req_valid | (N'(1) << i);
          waits[i] = 0;
        end
      end
      #1;
      w  = winner(req_valid, m_ptr, cdb_ready);
      ea = onehot(w);
      checks++;
      if (req_ack !== ea) begin
        failures++; $display("FAIL rand_ack c=%0d: got %b want %b", c, req_ack, ea);
      end
      for (int i = 0; i < N; i++) begin
        logic [N-1:0] s;
        s = req_valid >> i;
        if (s[0] && cdb_ready) waits[i]++;
      end
      if (w >= 0) begin
        checks++;
        if (waits[w] > N) begin
          failures++; $display("FAIL rand_fair c=%0d: fu%0d waited %0d want <= %0d", c, w,
                               waits[w], N);
        end
      end
      tick();
      if (w >= 0) drop(w);
      checks++;
      if (cdb_valid !== exp_valid || (exp_valid && (cdb_result !== exp_result ||
          cdb_tag !== exp_tag || cdb_dest_reg !== exp_dest || cdb_src !== exp_src))) begin
        failures++;
        $display("FAIL rand_bcast c=%0d: got v=%b r=%h t=%0d d=%0d s=%0d want v=%b r=%h t=%0d d=%0d s=%0d",
                 c, cdb_valid, cdb_result, cdb_tag, cdb_dest_reg, cdb_src,
                 exp_valid, exp_result, exp_tag, exp_dest, exp_src);
      end
    end
    req_valid = '0; cdb_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; cdb_ready = 1'b1;
    req_result = '0; req_tag = '0; req_dest_reg = '0;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
